gpio_pad_cfg_seq: RTL and testbench

- Per-pad configuration controller for the openframe GPIO pad ring. Drives every static sky130 gpiov2 control vector: dm, vtrip, slow, ib_mode, inp_dis, oeb, holdover and analog_*.
- Holds a 12-bit shadow config word per pad. After reset it runs a staggered init walk, then serves single-pad read/write requests from a req/ack host port.
- Sequences direction- and drive-critical changes through a tri-state settle window so a pad never glitches into an unintended drive state.
- Sits between the host register block and the gpio pad wrapper.

---
 rtl/gpio_cfg_pkg.sv | 42 ++++
 rtl/gpio_cfg_fanout.sv | 38 +++
 rtl/gpio_pad_cfg_seq.sv | 169 ++++++++++++++++
 tb/tb_gpio_pad_cfg_seq.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_cfg_pkg.sv
// Shared types and constants for the GPIO pad configuration sequencer.
// Field layout of the 12-bit per-pad config word and the sequencer states.
package gpio_cfg_pkg;

  localparam int CFG_W = 12;

  localparam int DM_LSB    = 0;
  localparam int DM_W      = 3;
  localparam int VTRIP_BIT = 3;
  localparam int SLOW_BIT  = 4;
  localparam int IB_BIT    = 5;
  localparam int INP_BIT   = 6;
  localparam int OEB_BIT   = 7;
  localparam int HOLD_BIT  = 8;
  localparam int AEN_BIT   = 9;
  localparam int ASEL_BIT  = 10;
  localparam int APOL_BIT  = 11;

  localparam logic [DM_W-1:0] DM_INPUT  = 3'b001;
  localparam logic [DM_W-1:0] DM_STRONG = 3'b110;
  localparam logic [DM_W-1:0] DM_ANALOG = 3'b000;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    ACK,
    SAFE,
    APPLY,
    RELEASE
  } cfg_state_e;

  // A change to drive mode, output enable or analog enable can glitch the pad.
  function automatic logic is_critical(
    input logic [CFG_W-1:0] old_w,
    input logic [CFG_W-1:0] new_w
  );
    return (old_w[DM_LSB+:DM_W] != new_w[DM_LSB+:DM_W])
        || (old_w[OEB_BIT] != new_w[OEB_BIT])
        || (old_w[AEN_BIT] != new_w[AEN_BIT]);
  endfunction

endpackage

// File: rtl/gpio_cfg_fanout.sv
// Unpacks the per-pad shadow words into the per-field pad control vectors.
// Purely combinational; the shadow words are already registered.
module gpio_cfg_fanout
  import gpio_cfg_pkg::*;
#(
  parameter int NPADS = 6
) (
  input  logic [NPADS-1:0][CFG_W-1:0] cfg,
  output logic [NPADS-1:0]            dm2,
  output logic [NPADS-1:0]            dm1,
  output logic [NPADS-1:0]            dm0,
  output logic [NPADS-1:0]            vtrip_sel,
  output logic [NPADS-1:0]            slow_sel,
  output logic [NPADS-1:0]            ib_mode_sel,
  output logic [NPADS-1:0]            inp_dis,
  output logic [NPADS-1:0]            oeb,
  output logic [NPADS-1:0]            holdover,
  output logic [NPADS-1:0]            analog_en,
  output logic [NPADS-1:0]            analog_sel,
  output logic [NPADS-1:0]            analog_pol
);

  for (genvar i = 0; i < NPADS; i++) begin : g_pad
    assign dm2[i]         = cfg[i][DM_LSB+2];
    assign dm1[i]         = cfg[i][DM_LSB+1];
    assign dm0[i]         = cfg[i][DM_LSB];
    assign vtrip_sel[i]   = cfg[i][VTRIP_BIT];
    assign slow_sel[i]    = cfg[i][SLOW_BIT];
    assign ib_mode_sel[i] = cfg[i][IB_BIT];
    assign inp_dis[i]     = cfg[i][INP_BIT];
    assign oeb[i]         = cfg[i][OEB_BIT];
    assign holdover[i]    = cfg[i][HOLD_BIT];
    assign analog_en[i]   = cfg[i][AEN_BIT];
    assign analog_sel[i]  = cfg[i][ASEL_BIT];
    assign analog_pol[i]  = cfg[i][APOL_BIT];
  end

endmodule

// File: rtl/gpio_pad_cfg_seq.sv
// Per-pad config sequencer: staggered init walk, then host read/write with
// a tri-state settle window around drive-critical changes.
module gpio_pad_cfg_seq
  import gpio_cfg_pkg::*;
#(
  parameter int               NPADS       = 6,
  parameter int               SETTLE_CYC  = 4,
  parameter int               STAGGER_CYC = 2,
  parameter logic [CFG_W-1:0] RST_CFG     = 12'h0C1,
  parameter logic [CFG_W-1:0] INIT_CFG    = 12'h0C1
) (
  input  logic             mclk,
  input  logic             reset_n,
  input  logic             cfg_req,
  input  logic             cfg_wr,
  input  logic [5:0]       cfg_pad,
  input  logic [CFG_W-1:0] cfg_wdata,
  output logic             cfg_ack,
  output logic             cfg_err,
  output logic [CFG_W-1:0] cfg_rdata,
  output logic             init_done,
  output logic             busy,
  output logic [NPADS-1:0] gpio_dm2,
  output logic [NPADS-1:0] gpio_dm1,
  output logic [NPADS-1:0] gpio_dm0,
  output logic [NPADS-1:0] gpio_vtrip_sel,
  output logic [NPADS-1:0] gpio_slow_sel,
  output logic [NPADS-1:0] gpio_ib_mode_sel,
  output logic [NPADS-1:0] gpio_inp_dis,
  output logic [NPADS-1:0] gpio_oeb,
  output logic [NPADS-1:0] gpio_holdover,
  output logic [NPADS-1:0] gpio_analog_en,
  output logic [NPADS-1:0] gpio_analog_sel,
  output logic [NPADS-1:0] gpio_analog_pol
);

  localparam int PW = (NPADS > 1) ? $clog2(NPADS) : 1;
  localparam int CW = 16;

  localparam logic [CW-1:0]    SET_LAST = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0]    STG_LAST = CW'(STAGGER_CYC - 1);
  localparam logic [PW-1:0]    PAD_LAST = PW'(NPADS - 1);
  localparam logic [CFG_W-1:0] OEB_MSK  = CFG_W'(1) << OEB_BIT;

  cfg_state_e                  state;
  logic [NPADS-1:0][CFG_W-1:0] shadow;
  logic [PW-1:0]               pad_cnt;
  logic [PW-1:0]               tgt;
  logic [PW-1:0]               idx;
  logic [CW-1:0]               cyc_cnt;
  logic [CFG_W-1:0]            wd;
  logic [CFG_W-1:0]            cur;
  logic                        pad_ok;
  logic                        crit;

  assign idx    = cfg_pad[PW-1:0];
  assign pad_ok = ({1'b0, cfg_pad} < 7'(NPADS));
  assign cur    = shadow[idx];
  assign crit   = is_critical(cur, cfg_wdata);

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= INIT;
      shadow    <= {NPADS{RST_CFG}};
      pad_cnt   <= '0;
      cyc_cnt   <= '0;
      tgt       <= '0;
      wd        <= '0;
      cfg_ack   <= 1'b0;
      cfg_err   <= 1'b0;
      cfg_rdata <= '0;
      init_done <= 1'b0;
      busy      <= 1'b0;
    end else begin
      cfg_ack <= 1'b0;
      unique case (state)
        INIT: begin
          busy <= 1'b1;
          if (cyc_cnt == '0) shadow[pad_cnt] <= INIT_CFG;
          if (cyc_cnt == STG_LAST) begin
            cyc_cnt <= '0;
            if (pad_cnt == PAD_LAST) begin
              init_done <= 1'b1;
              busy      <= 1'b0;
              state     <= IDLE;
            end else begin
              pad_cnt <= pad_cnt + 1'b1;
            end
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
        IDLE: begin
          if (cfg_req) begin
            busy <= 1'b1;
            if (!pad_ok || !cfg_wr) begin
              cfg_ack   <= 1'b1;
              cfg_err   <= !pad_ok;
              cfg_rdata <= pad_ok ? cur : '0;
              state     <= ACK;
            end else if (!crit) begin
              shadow[idx] <= cfg_wdata;
              cfg_ack     <= 1'b1;
              cfg_err     <= 1'b0;
              cfg_rdata   <= cfg_wdata;
              state       <= ACK;
            end else begin
              // Tri-state the pad first; the rest of the word stays old.
              shadow[idx][OEB_BIT] <= 1'b1;
              tgt     <= idx;
              wd      <= cfg_wdata;
              cyc_cnt <= '0;
              state   <= SAFE;
            end
          end
        end
        ACK: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        SAFE: begin
          if (cyc_cnt == SET_LAST) begin
            cyc_cnt     <= '0;
            shadow[tgt] <= wd | OEB_MSK;
            state       <= APPLY;
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
        APPLY: begin
          if (cyc_cnt == SET_LAST) begin
            cyc_cnt     <= '0;
            shadow[tgt] <= wd;
            cfg_ack     <= 1'b1;
            cfg_err     <= 1'b0;
            cfg_rdata   <= wd;
            state       <= RELEASE;
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
        RELEASE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= INIT;
      endcase
    end
  end

  gpio_cfg_fanout #(
    .NPADS(NPADS)
  ) u_fanout (
    .cfg        (shadow),
    .dm2        (gpio_dm2),
    .dm1        (gpio_dm1),
    .dm0        (gpio_dm0),
    .vtrip_sel  (gpio_vtrip_sel),
    .slow_sel   (gpio_slow_sel),
    .ib_mode_sel(gpio_ib_mode_sel),
    .inp_dis    (gpio_inp_dis),
    .oeb        (gpio_oeb),
    .holdover   (gpio_holdover),
    .analog_en  (gpio_analog_en),
    .analog_sel (gpio_analog_sel),
    .analog_pol (gpio_analog_pol)
  );

endmodule

// File: tb/tb_gpio_pad_cfg_seq.sv
// Directed self-checking bench for gpio_pad_cfg_seq.
// Six pads, SETTLE_CYC=4, STAGGER_CYC=2, INIT_CFG=0x0C6.
module tb_gpio_pad_cfg_seq;

  localparam int NP = 6;

  logic          mclk = 1'b0;
  logic          reset_n;
  logic          cfg_req;
  logic          cfg_wr;
  logic [5:0]    cfg_pad;
  logic [11:0]   cfg_wdata;
  logic          cfg_ack;
  logic          cfg_err;
  logic [11:0]   cfg_rdata;
  logic          init_done;
  logic          busy;
  logic [NP-1:0] gpio_dm2;
  logic [NP-1:0] gpio_dm1;
  logic [NP-1:0] gpio_dm0;
  logic [NP-1:0] gpio_vtrip_sel;
  logic [NP-1:0] gpio_slow_sel;
  logic [NP-1:0] gpio_ib_mode_sel;
  logic [NP-1:0] gpio_inp_dis;
  logic [NP-1:0] gpio_oeb;
  logic [NP-1:0] gpio_holdover;
  logic [NP-1:0] gpio_analog_en;
  logic [NP-1:0] gpio_analog_sel;
  logic [NP-1:0] gpio_analog_pol;

  int n_cmp = 0;
  int n_err = 0;
  logic [11:0] exp_w [NP];

  gpio_pad_cfg_seq #(
    .NPADS      (NP),
    .SETTLE_CYC (4),
    .STAGGER_CYC(2),
    .RST_CFG    (12'h0C1),
    .INIT_CFG   (12'h0C6)
  ) dut (
    .mclk            (mclk),
    .reset_n         (reset_n),
    .cfg_req         (cfg_req),
    .cfg_wr          (cfg_wr),
    .cfg_pad         (cfg_pad),
    .cfg_wdata       (cfg_wdata),
    .cfg_ack         (cfg_ack),
    .cfg_err         (cfg_err),
    .cfg_rdata       (cfg_rdata),
    .init_done       (init_done),
    .busy            (busy),
    .gpio_dm2        (gpio_dm2),
    .gpio_dm1        (gpio_dm1),
    .gpio_dm0        (gpio_dm0),
    .gpio_vtrip_sel  (gpio_vtrip_sel),
    .gpio_slow_sel   (gpio_slow_sel),
    .gpio_ib_mode_sel(gpio_ib_mode_sel),
    .gpio_inp_dis    (gpio_inp_dis),
    .gpio_oeb        (gpio_oeb),
    .gpio_holdover   (gpio_holdover),
    .gpio_analog_en  (gpio_analog_en),
    .gpio_analog_sel (gpio_analog_sel),
    .gpio_analog_pol (gpio_analog_pol)
  );

  always #5 mclk = ~mclk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] pad_word(input int p);
    return {gpio_analog_pol[p], gpio_analog_sel[p],
            gpio_analog_en[p], gpio_holdover[p],
            gpio_oeb[p], gpio_inp_dis[p],
            gpio_ib_mode_sel[p], gpio_slow_sel[p],
            gpio_vtrip_sel[p], gpio_dm2[p],
            gpio_dm1[p], gpio_dm0[p]};
  endfunction

  task automatic check_all(input string tag);
    for (int q = 0; q < NP; q++)
      check($sformatf("%s_pad%0d", tag, q), 32'(pad_word(q)),
            32'(exp_w[q]));
  endtask

  // Walk from reset release; optionally a read of pad 3 is raised mid-walk.
  task automatic init_walk(input bit with_req);
    for (int c = 1; c <= 12; c++) begin
      @(posedge mclk); #1;
      for (int k = 0; k < NP; k++)
        check($sformatf("init_c%0d_p%0d", c, k), 32'(pad_word(k)),
              (c >= 2 * k + 1) ? 32'h0C6 : 32'h0C1);
      check($sformatf("init_oeb_c%0d", c), 32'(gpio_oeb), 32'h3F);
      check($sformatf("init_done_c%0d", c), 32'(init_done),
            32'(c >= 12));
      check($sformatf("init_busy_c%0d", c), 32'(busy), 32'(c < 12));
      check($sformatf("init_ack_c%0d", c), 32'(cfg_ack), 32'h0);
      if (with_req && c == 3) begin
        cfg_wr  = 1'b0;
        cfg_pad = 6'd3;
        cfg_req = 1'b1;
      end
    end
    for (int k = 0; k < NP; k++) exp_w[k] = 12'h0C6;
  endtask

  task automatic do_req(
    input  logic        wr,
    input  logic [5:0]  pad,
    input  logic [11:0] wdata,
    output int          lat,
    output logic [11:0] rd,
    output logic        err
  );
    cfg_wr    = wr;
    cfg_pad   = pad;
    cfg_wdata = wdata;
    cfg_req   = 1'b1;
    lat = 0;
    rd  = '0;
    err = 1'b0;
    while (lat < 40) begin
      @(posedge mclk); #1;
      lat++;
      if (cfg_ack) break;
    end
    rd  = cfg_rdata;
    err = cfg_err;
    cfg_req = 1'b0;
    @(posedge mclk); #1;
    check("ack_fall", 32'(cfg_ack), 32'h0);
    check("busy_fall", 32'(busy), 32'h0);
  endtask

  task automatic crit_write(
    input int          p,
    input logic [11:0] wd,
    input logic [11:0] sw,
    input logic [11:0] aw
  );
    cfg_wr    = 1'b1;
    cfg_pad   = 6'(p);
    cfg_wdata = wd;
    cfg_req   = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(posedge mclk); #1;
      check($sformatf("crit_p%0d_c%0d", p, c), 32'(pad_word(p)),
            (c <= 4) ? 32'(sw) : (c <= 8) ? 32'(aw) : 32'(wd));
      check($sformatf("crit_ack_c%0d", c), 32'(cfg_ack),
            32'(c == 9));
      check($sformatf("crit_busy_c%0d", c), 32'(busy), 32'h1);
      for (int q = 0; q < NP; q++)
        if (q != p)
          check($sformatf("crit_other%0d_c%0d", q, c),
                32'(pad_word(q)), 32'(exp_w[q]));
    end
    check("crit_err", 32'(cfg_err), 32'h0);
    check("crit_rdata", 32'(cfg_rdata), 32'(wd));
    cfg_req = 1'b0;
    exp_w[p] = wd;
    @(posedge mclk); #1;
    check("crit_ack_fall", 32'(cfg_ack), 32'h0);
    check("crit_busy_fall", 32'(busy), 32'h0);
  endtask

  int          lat;
  logic [11:0] rd;
  logic        err;

  initial begin
    reset_n   = 1'b0;
    cfg_req   = 1'b0;
    cfg_wr    = 1'b0;
    cfg_pad   = '0;
    cfg_wdata = '0;
    for (int k = 0; k < NP; k++) exp_w[k] = 12'h0C1;
    repeat (3) @(posedge mclk);
    #1;
    check_all("rst");
    check("rst_ack", 32'(cfg_ack), 32'h0);
    check("rst_init_done", 32'(init_done), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_rdata", 32'(cfg_rdata), 32'h0);
    reset_n = 1'b1;

    // Read held across the init walk is served by the first IDLE sample.
    init_walk(1'b1);
    @(posedge mclk); #1;
    check("held_ack", 32'(cfg_ack), 32'h1);
    check("held_rdata", 32'(cfg_rdata), 32'h0C6);
    check("held_err", 32'(cfg_err), 32'h0);
    cfg_req = 1'b0;
    @(posedge mclk); #1;
    check("held_ack_fall", 32'(cfg_ack), 32'h0);

    do_req(1'b0, 6'd3, 12'h000, lat, rd, err);
    check("rd3_lat", 32'(lat), 32'd1);
    check("rd3_rdata", 32'(rd), 32'h0C6);
    check("rd3_err", 32'(err), 32'h0);

    do_req(1'b1, 6'd2, 12'h0CE, lat, rd, err);
    exp_w[2] = 12'h0CE;
    check("fast_lat", 32'(lat), 32'd1);
    check("fast_err", 32'(err), 32'h0);
    check("fast_vtrip", 32'(gpio_vtrip_sel), 32'h04);
    check("fast_dm2", 32'(gpio_dm2), 32'h3F);
    check("fast_oeb", 32'(gpio_oeb), 32'h3F);
    check_all("fast");

    do_req(1'b1, 6'd2, 12'h0CE, lat, rd, err);
    check("same_lat", 32'(lat), 32'd1);
    check("same_err", 32'(err), 32'h0);
    check_all("same");

    crit_write(1, 12'h046, 12'h0C6, 12'h0C6);
    crit_write(0, 12'h041, 12'h0C6, 12'h0C1);
    crit_write(0, 12'h046, 12'h0C1, 12'h0C6);
    check("oeb_after_crit", 32'(gpio_oeb), 32'h3C);

    do_req(1'b0, 6'd1, 12'h000, lat, rd, err);
    check("rd1_lat", 32'(lat), 32'd1);
    check("rd1_rdata", 32'(rd), 32'h046);

    do_req(1'b1, 6'd7, 12'h000, lat, rd, err);
    check("bad7_lat", 32'(lat), 32'd1);
    check("bad7_err", 32'(err), 32'h1);
    check("bad7_rdata", 32'(rd), 32'h0);
    check_all("bad7");

    do_req(1'b0, 6'd63, 12'h000, lat, rd, err);
    check("bad63_err", 32'(err), 32'h1);
    check("bad63_rdata", 32'(rd), 32'h0);

    do_req(1'b0, 6'd5, 12'h000, lat, rd, err);
    check("rd5_err", 32'(err), 32'h0);
    check("rd5_rdata", 32'(rd), 32'h0C6);

    // Reset lands mid-APPLY of a critical write to pad 3.
    cfg_wr    = 1'b1;
    cfg_pad   = 6'd3;
    cfg_wdata = 12'h041;
    cfg_req   = 1'b1;
    repeat (6) @(posedge mclk);
    #1;
    check("pre_rst_p3", 32'(pad_word(3)), 32'h0C1);
    #2;
    reset_n = 1'b0;
    #1;
    cfg_req = 1'b0;
    for (int k = 0; k < NP; k++) exp_w[k] = 12'h0C1;
    check_all("async_rst");
    check("async_init_done", 32'(init_done), 32'h0);
    check("async_busy", 32'(busy), 32'h0);
    check("async_ack", 32'(cfg_ack), 32'h0);
    repeat (2) @(posedge mclk);
    #1;
    reset_n = 1'b1;
    init_walk(1'b0);
    check_all("rewalk");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
